// File: rtl/fanout_pkg.sv
// Shared definitions for the fanout ready-combine and eager-fork stages.
package fanout_pkg;

    localparam int NUM_OUT_DEFAULT    = 6;
    localparam int PAYLOAD_WIDTH      = 16;
    localparam int DATA_WIDTH_DEFAULT = PAYLOAD_WIDTH + 1;

    // A stream token: 16-bit payload plus one stream-control bit on top.
    typedef struct packed {
        logic                     ctrl;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } token_t;

endpackage

// File: rtl/fanout_reg_fifo.sv
// Small pointer FIFO with a registered ready, used to cut the combinational
// ready path between the fork consumers and the upstream producer.
module fanout_reg_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push, do_pop;

    assign do_push = push & (count_q != DEPTH_C);
    assign do_pop  = pop & (count_q != '0);

    // Next-state for storage, pointers (wrapping modulo DEPTH), count and ready.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        ready_d = (count_d < DEPTH_C);
    end

    // Control state; ready stays low throughout reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Token storage needs no reset; stale entries are never presented as valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign ready = ready_q;

endmodule

// File: rtl/fanout_eager_fork.sv
// Buffered eager fork: broadcasts each head token to every active destination,
// letting each one accept in its own cycle, and retires once all are done.
module fanout_eager_fork
    import fanout_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int NUM_OUT    = NUM_OUT_DEFAULT,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_OUT-1:0]    out_active,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]    out_valid,
    input  logic [NUM_OUT-1:0]    out_ready
);

    logic               push;
    logic               retire;
    logic               empty;
    logic [NUM_OUT-1:0] sent_q, sent_d;
    logic [NUM_OUT-1:0] xfer;
    logic [NUM_OUT-1:0] done;

    assign push = in_valid & in_ready;

    fanout_reg_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (retire),
        .wdata (in_data),
        .rdata (out_data),
        .empty (empty),
        .ready (in_ready)
    );

    // Valid fan-out against the live mask; retire when every destination is done.
    always_comb begin
        out_valid = {NUM_OUT{~empty}} & out_active & ~sent_q;
        xfer      = out_valid & out_ready;
        done      = ~out_active | sent_q | xfer;
        retire    = ~empty & (&done);
        sent_d    = retire ? '0 : (sent_q | xfer);
    end

    // Per-destination delivery record for the current head token.
    always_ff @(posedge clk) begin
        if (reset) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end

endmodule

// File: tb/tb_fanout_eager_fork.sv
// Self-checking bench for fanout_eager_fork: a scoreboard queue of accepted
// tokens with per-destination delivery state predicts every output cycle.
module tb_fanout_eager_fork;

    localparam int DW    = 17;
    localparam int NO    = 6;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [NO-1:0] out_active;
    logic [DW-1:0] out_data;
    logic [NO-1:0] out_valid;
    logic [NO-1:0] out_ready;

    int errorCount = 0;
    int checkCount = 0;

    logic [DW-1:0] modelQ [$];
    logic [NO-1:0] modelSent;
    logic          modelReady;
    bit            modelKnown = 0;

    int            xferCnt [NO];
    int            validCycles;
    int            readyLowCycles;
    logic [DW-1:0] dest0Log [$];

    fanout_eager_fork #(
        .DATA_WIDTH (DW),
        .NUM_OUT    (NO),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_active (out_active),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic clearStats();
        for (int i = 0; i < NO; i++) xferCnt[i] = 0;
        validCycles    = 0;
        readyLowCycles = 0;
        dest0Log.delete();
    endtask

    // One clock cycle: drive inputs, check outputs against the scoreboard at
    // the falling edge, then advance the scoreboard across the rising edge.
    task automatic applyStimulus(input logic rst, input logic v, input logic [DW-1:0] d,
                                 input logic [NO-1:0] act, input logic [NO-1:0] rdy);
        logic          nonEmpty;
        logic [NO-1:0] expValid, expXfer, expDone, dutXfer;
        logic          expRetire, expPush;
        reset      = rst;
        in_valid   = v;
        in_data    = d;
        out_active = act;
        out_ready  = rdy;
        @(negedge clk);
        dutXfer = out_valid & rdy;
        for (int i = 0; i < NO; i++) if (dutXfer[i]) xferCnt[i]++;
        if (dutXfer[0]) dest0Log.push_back(out_data);
        if (out_valid != '0) validCycles++;
        if (!in_ready) readyLowCycles++;
        if (modelKnown) begin
            nonEmpty = (modelQ.size() > 0);
            expValid = nonEmpty ? (act & ~modelSent) : '0;
            checkOutput("in_ready", 32'(in_ready), 32'(modelReady));
            checkOutput("out_valid", 32'(out_valid), 32'(expValid));
            if (nonEmpty) checkOutput("out_data", 32'(out_data), 32'(modelQ[0]));
            expXfer   = expValid & rdy;
            expDone   = ~act | modelSent | expXfer;
            expRetire = nonEmpty & (&expDone);
            expPush   = v & modelReady;
            if (rst) begin
                modelQ.delete();
                modelSent  = '0;
                modelReady = 1'b0;
            end else begin
                if (expRetire) begin
                    void'(modelQ.pop_front());
                    modelSent = '0;
                end else begin
                    modelSent = modelSent | expXfer;
                end
                if (expPush) modelQ.push_back(d);
                modelReady = (modelQ.size() < DEPTH);
            end
        end else if (rst) begin
            modelQ.delete();
            modelSent  = '0;
            modelReady = 1'b0;
            modelKnown = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_active = '0; out_ready = '0;
        clearStats();

        // Reset, then confirm registered ready rises one cycle after release.
        applyStimulus(1, 0, '0, '0, '0);
        applyStimulus(1, 0, '0, '0, '0);
        applyStimulus(0, 0, '0, 6'b000011, 6'b000011);
        applyStimulus(0, 0, '0, 6'b000011, 6'b000011);

        // Single token to two ready destinations: one-cycle latency, immediate retire.
        clearStats();
        applyStimulus(0, 1, 17'h000A5, 6'b000011, 6'b000011);
        applyStimulus(0, 0, '0, 6'b000011, 6'b000011);
        applyStimulus(0, 0, '0, 6'b000011, 6'b000011);
        checkOutput("basic_xfer0", 32'(xferCnt[0]), 32'd1);
        checkOutput("basic_xfer1", 32'(xferCnt[1]), 32'd1);
        checkOutput("basic_ready_low", 32'(readyLowCycles), 32'd0);

        // Staggered readiness: dest0, then dest2, then dest1.
        clearStats();
        applyStimulus(0, 1, 17'h10123, 6'b000111, 6'b000000);
        applyStimulus(0, 0, '0, 6'b000111, 6'b000001);
        applyStimulus(0, 0, '0, 6'b000111, 6'b000100);
        applyStimulus(0, 0, '0, 6'b000111, 6'b000010);
        applyStimulus(0, 0, '0, 6'b000111, 6'b000111);
        for (int i = 0; i < 3; i++) checkOutput($sformatf("stagger_xfer%0d", i), 32'(xferCnt[i]), 32'd1);

        // Backpressure: two tokens fill the FIFO, the third waits for space.
        clearStats();
        applyStimulus(0, 1, 17'h00001, 6'b000011, 6'b000000);
        applyStimulus(0, 1, 17'h00002, 6'b000011, 6'b000000);
        applyStimulus(0, 1, 17'h00003, 6'b000011, 6'b000000);
        checkOutput("bp_full_ready", 32'(in_ready), 32'd0);
        applyStimulus(0, 1, 17'h00003, 6'b000011, 6'b000000);
        applyStimulus(0, 1, 17'h00003, 6'b000011, 6'b000011);
        applyStimulus(0, 1, 17'h00003, 6'b000011, 6'b000011);
        applyStimulus(0, 0, '0, 6'b000011, 6'b000011);
        applyStimulus(0, 0, '0, 6'b000011, 6'b000011);
        checkOutput("bp_count", 32'(dest0Log.size()), 32'd3);
        if (dest0Log.size() == 3) begin
            for (int i = 0; i < 3; i++)
                checkOutput($sformatf("bp_order%0d", i), 32'(dest0Log[i]), 32'(i + 1));
        end

        // Mask change while partly delivered: dropping dest1 retires the head.
        clearStats();
        applyStimulus(0, 1, 17'h00055, 6'b000011, 6'b000000);
        applyStimulus(0, 0, '0, 6'b000011, 6'b000001);
        applyStimulus(0, 0, '0, 6'b000011, 6'b000000);
        applyStimulus(0, 0, '0, 6'b000001, 6'b000000);
        applyStimulus(0, 1, 17'h00066, 6'b000001, 6'b000011);
        applyStimulus(0, 0, '0, 6'b000001, 6'b000011);
        applyStimulus(0, 0, '0, 6'b000001, 6'b000011);
        checkOutput("mask_xfer0", 32'(xferCnt[0]), 32'd2);
        checkOutput("mask_xfer1", 32'(xferCnt[1]), 32'd0);

        // No active destinations: a stream drains silently at full rate.
        clearStats();
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 17'(16'hB000 + i), 6'b000000, 6'b111111);
        applyStimulus(0, 0, '0, 6'b000000, 6'b111111);
        applyStimulus(0, 0, '0, 6'b000000, 6'b111111);
        checkOutput("drain_valid_cycles", 32'(validCycles), 32'd0);
        checkOutput("drain_ready_low", 32'(readyLowCycles), 32'd0);

        // Reset with two tokens held and one destination already served.
        applyStimulus(0, 1, 17'h00C01, 6'b000011, 6'b000000);
        applyStimulus(0, 1, 17'h00C02, 6'b000011, 6'b000000);
        applyStimulus(0, 0, '0, 6'b000011, 6'b000001);
        applyStimulus(1, 0, '0, 6'b000011, 6'b000000);
        clearStats();
        applyStimulus(0, 0, '0, 6'b000011, 6'b000011);
        applyStimulus(0, 0, '0, 6'b000011, 6'b000011);
        applyStimulus(0, 0, '0, 6'b000011, 6'b000011);
        checkOutput("rst_valid_cycles", 32'(validCycles), 32'd0);

        // Random traffic with varying readiness, checked cycle by cycle.
        for (int i = 0; i < 200; i++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), 17'($urandom),
                          6'b101101, 6'($urandom));
        end
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, '0, 6'b101101, 6'b111111);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
